tp_input_ctrl: RTL and testbench

Player-input conditioning stage for the Time Pilot core. It decodes PS/2 key events and the two HPS joystick words into registered per-player control lines, start buttons and a frame-timed coin pulse. It sits between the HPS I/O block and the `time_pilot` core's `start*`, `coin1` and `up/down/left/right/fire*` inputs. The coin pulse is stretched and rate-limited against `vblank` so the game's coin sampler never misses or double-counts a coin.

---
 rtl/tp_input_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tp_input_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_input_ctrl.sv
// tp_input_ctrl: player-input conditioning for the Time Pilot core.
//
// Decodes PS/2 key events and two HPS joystick words into registered
// per-player control lines, start buttons and a vblank-timed coin pulse.
//
// Ports
//   clk_sys   in   1   system clock
//   reset_n   in   1   async active-low reset
//   ps2_key   in  11   {toggle, pressed, extended, scancode[7:0]}
//   joy0      in  16   player 1 joystick {.., coin, start2, start1, fire, up, down, left, right}
//   joy1      in  16   player 2 joystick, bits [4:0] used
//   vblank    in   1   vertical blank, synchronous to clk_sys
//   p1_ctrl   out  5   {fire, up, down, left, right}
//   p2_ctrl   out  5   same packing
//   start1    out  1
//   start2    out  1
//   coin      out  1   stretched, rate-limited coin pulse

// Per-player merge of key latches and joystick, with opposing-direction
// cancellation on each axis. Packing: {fire, up, down, left, right}.
module tp_player_cond (
    input  logic [4:0] keys,
    input  logic [4:0] joy,
    output logic [4:0] ctrl
);
    logic [4:0] merged;

    always_comb begin
        merged = keys | joy;
        ctrl   = merged;
        if (merged[3] && merged[2]) ctrl[3:2] = 2'b00;
        if (merged[1] && merged[0]) ctrl[1:0] = 2'b00;
    end
endmodule

module tp_input_ctrl #(
    parameter int COIN_FRAMES = 4,
    parameter int COIN_GAP    = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic        vblank,
    output logic [4:0]  p1_ctrl,
    output logic [4:0]  p2_ctrl,
    output logic        start1,
    output logic        start2,
    output logic        coin
);
    localparam int         NUM_PLAYERS = 2;
    localparam logic [3:0] FRAMES_L    = 4'(COIN_FRAMES);
    localparam logic [3:0] GAP_L       = 4'(COIN_GAP);

    // ---------------- key latches ----------------
    logic [NUM_PLAYERS-1:0][4:0] key_dir;
    logic [NUM_PLAYERS-1:0][4:0] joy_dir;
    logic [NUM_PLAYERS-1:0][4:0] dir_cond;
    logic key_s1, key_s2, coin_a, coin_b;
    logic tog_q, primed;
    logic key_evt;

    // primed masks the first cycle after reset so a toggle that is already
    // high at release is absorbed into tog_q instead of decoded.
    assign key_evt = primed & (ps2_key[10] ^ tog_q);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            primed  <= 1'b0;
            key_dir <= '0;
            key_s1  <= 1'b0;
            key_s2  <= 1'b0;
            coin_a  <= 1'b0;
            coin_b  <= 1'b0;
        end else begin
            tog_q  <= ps2_key[10];
            primed <= 1'b1;
            if (key_evt) begin
                // Extended bit is ignored: arrows and keypad share codes.
                case (ps2_key[7:0])
                    8'h75:        key_dir[0][3] <= ps2_key[9];
                    8'h72:        key_dir[0][2] <= ps2_key[9];
                    8'h6B:        key_dir[0][1] <= ps2_key[9];
                    8'h74:        key_dir[0][0] <= ps2_key[9];
                    8'h29, 8'h14: key_dir[0][4] <= ps2_key[9];
                    8'h05, 8'h16: key_s1        <= ps2_key[9];
                    8'h06, 8'h1E: key_s2        <= ps2_key[9];
                    8'h2E:        coin_a        <= ps2_key[9];
                    8'h36:        coin_b        <= ps2_key[9];
                    8'h2D:        key_dir[1][3] <= ps2_key[9];
                    8'h2B:        key_dir[1][2] <= ps2_key[9];
                    8'h23:        key_dir[1][1] <= ps2_key[9];
                    8'h34:        key_dir[1][0] <= ps2_key[9];
                    8'h1C:        key_dir[1][4] <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-player merge ----------------
    assign joy_dir[0] = joy0[4:0];
    assign joy_dir[1] = joy1[4:0];

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        tp_player_cond u_cond (
            .keys (key_dir[g]),
            .joy  (joy_dir[g]),
            .ctrl (dir_cond[g])
        );
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_ctrl <= '0;
            p2_ctrl <= '0;
            start1  <= 1'b0;
            start2  <= 1'b0;
        end else begin
            p1_ctrl <= dir_cond[0];
            p2_ctrl <= dir_cond[1];
            start1  <= key_s1 | joy0[5];
            start2  <= key_s2 | joy0[6];
        end
    end

    // ---------------- coin stretcher ----------------
    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_t;

    coin_st_t   state, state_nxt;
    logic [3:0] cnt, cnt_nxt, cnt_dec;
    logic       creq, creq_q, vblank_q, vb_rise, pend, take;

    assign creq    = coin_a | coin_b | joy0[7];
    assign vb_rise = vblank & ~vblank_q;
    assign cnt_dec = cnt - 4'd1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            creq_q   <= 1'b0;
            vblank_q <= 1'b0;
            pend     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            creq_q   <= creq;
            vblank_q <= vblank;
            // A new request wins over consumption, so an edge in the same
            // cycle IDLE takes the pending coin is kept for the next one.
            if (creq && !creq_q) pend <= 1'b1;
            else if (take)       pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        coin      = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    take      = 1'b1;
                    cnt_nxt   = FRAMES_L;
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                coin = 1'b1;
                if (vb_rise) begin
                    if (cnt_dec == 4'd0) begin
                        cnt_nxt   = GAP_L;
                        state_nxt = GAP;
                    end else begin
                        cnt_nxt = cnt_dec;
                    end
                end
            end
            GAP: begin
                if (vb_rise) begin
                    cnt_nxt = cnt_dec;
                    if (cnt_dec == 4'd0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic unused;
    assign unused = ^{ps2_key[8], joy0[15:8], joy1[15:5]};
endmodule

// File: tb/tb_tp_input_ctrl.sv
// Bench for tp_input_ctrl: random and directed stimulus, reference model
// producing per-cycle expected outputs into a queue, and a negedge monitor
// that pops and compares.
module tb_tp_input_ctrl;
    localparam int COIN_FRAMES = 4;
    localparam int COIN_GAP    = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] joy0 = '0, joy1 = '0;
    logic        vblank = 1'b0;
    logic [4:0]  p1_ctrl, p2_ctrl;
    logic        start1, start2, coin;

    tp_input_ctrl #(.COIN_FRAMES(COIN_FRAMES), .COIN_GAP(COIN_GAP)) dut (
        .clk_sys (clk_sys), .reset_n (reset_n), .ps2_key (ps2_key),
        .joy0 (joy0), .joy1 (joy1), .vblank (vblank),
        .p1_ctrl (p1_ctrl), .p2_ctrl (p2_ctrl),
        .start1 (start1), .start2 (start2), .coin (coin)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [4:0] p1;
        logic [4:0] p2;
        logic       s1;
        logic       s2;
        logic       coin;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0, n_err = 0;

    // ---------------- reference model ----------------
    // Flags: 0..4 p1 {right,left,down,up,fire}, 5..9 p2 same,
    // 10 start1, 11 start2, 12 coin_a, 13 coin_b.
    bit flag [16];
    bit m_tog, m_primed, m_creq_q, m_vb_q, m_pend;
    int pulse_left, gap_left;

    function automatic int key_slot(input logic [7:0] code);
        case (code)
            8'h74: return 0;  8'h6B: return 1;  8'h72: return 2;  8'h75: return 3;
            8'h29, 8'h14: return 4;
            8'h34: return 5;  8'h23: return 6;  8'h2B: return 7;  8'h2D: return 8;
            8'h1C: return 9;
            8'h05, 8'h16: return 10;
            8'h06, 8'h1E: return 11;
            8'h2E: return 12;
            8'h36: return 13;
            default: return -1;
        endcase
    endfunction

    function automatic logic [4:0] cancel(input logic [4:0] v);
        logic [4:0] r;
        r = v;
        if (v[3] && v[2]) r[3:2] = 2'b00;
        if (v[1] && v[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    task automatic model_step();
        obs_t       o;
        logic [4:0] k1, k2;
        bit         creq, rise, vbr;
        int         slot;
        if (!reset_n) begin
            foreach (flag[i]) flag[i] = 1'b0;
            m_tog = 0; m_primed = 0; m_creq_q = 0; m_vb_q = 0; m_pend = 0;
            pulse_left = 0; gap_left = 0;
            exp_q.push_back('0);
            return;
        end
        for (int i = 0; i < 5; i++) begin
            k1[i] = flag[i];
            k2[i] = flag[5+i];
        end
        o.p1 = cancel(k1 | joy0[4:0]);
        o.p2 = cancel(k2 | joy1[4:0]);
        o.s1 = flag[10] | joy0[5];
        o.s2 = flag[11] | joy0[6];
        creq = flag[12] | flag[13] | joy0[7];
        rise = creq && !m_creq_q;
        vbr  = vblank && !m_vb_q;
        if (pulse_left > 0) begin
            if (vbr) begin
                pulse_left--;
                if (pulse_left == 0) gap_left = COIN_GAP;
            end
        end else if (gap_left > 0) begin
            if (vbr) gap_left--;
        end else if (m_pend) begin
            m_pend     = 0;
            pulse_left = COIN_FRAMES;
        end
        if (rise) m_pend = 1;
        o.coin   = (pulse_left > 0);
        m_creq_q = creq;
        m_vb_q   = vblank;
        if (m_primed && (ps2_key[10] != m_tog)) begin
            slot = key_slot(ps2_key[7:0]);
            if (slot >= 0) flag[slot] = ps2_key[9];
        end
        m_tog    = ps2_key[10];
        m_primed = 1;
        exp_q.push_back(o);
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk_sys);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{p1: p1_ctrl, p2: p2_ctrl, s1: start1, s2: start2, coin: coin};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs @%0t: got p1=%b p2=%b s1=%b s2=%b coin=%b, want p1=%b p2=%b s1=%b s2=%b coin=%b",
                             $time, a.p1, a.p2, a.s1, a.s2, a.coin, e.p1, e.p2, e.s1, e.s2, e.coin);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit vb_auto = 1;
    int vb_ph = 0, vb_period = 12;
    int coin_rises = 0;
    bit coin_prev = 0;
    logic [7:0] codes [17] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16,
                               8'h06, 8'h1E, 8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C};

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        if (coin && !coin_prev) coin_rises++;
        coin_prev = coin;
        if (vb_auto) begin
            vb_ph++;
            if (vb_ph >= vb_period) vb_ph = 0;
            vblank = (vb_ph < 3);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input bit pressed, input bit ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_coin(input string name);
        for (int i = 0; i < 40 && !coin; i++) tick();
        check(name, int'(coin), 1);
    endtask

    task automatic joy_coin();
        joy0[7] = 1'b1; tick();
        joy0[7] = 1'b0; ticks(2);
    endtask

    task automatic async_reset(input int hold);
        @(negedge clk_sys);
        #1 reset_n = 1'b0;
        #1 check("reset_async_coin", int'(coin), 0);
        check("reset_async_p1", int'(p1_ctrl), 0);
        ticks(hold);
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_joy();
        logic [15:0] j;
        j = 16'($urandom);
        for (int i = 0; i < 7; i++) j[i] = ($urandom_range(0, 3) == 0);
        j[7] = ($urandom_range(0, 15) == 0);
        return j;
    endfunction

    initial begin
        // Reset with the toggle already high: nothing may decode afterwards.
        ps2_key = 11'h400;
        #2 reset_n = 1'b0;
        #1 check("reset_state", int'({p1_ctrl, p2_ctrl, start1, start2, coin}), 0);
        ticks(3);
        reset_n = 1'b1;
        ticks(100);
        check("primed_quiet_p1", int'(p1_ctrl), 0);

        // Extended up-arrow press and release.
        key(1, 1, 8'h75); ticks(2);
        check("key_up_press", int'(p1_ctrl), 5'b01000);
        ticks(2);
        key(0, 1, 8'h75); ticks(2);
        check("key_up_release", int'(p1_ctrl), 0);
        ticks(2);

        // Joystick opposing directions.
        joy0 = 16'h000C; ticks(3);
        check("joy_up_down", int'(p1_ctrl[3:2]), 0);
        joy0 = 16'h0009; ticks(3);
        check("joy_up_right", int'(p1_ctrl), 5'b01001);
        joy0 = 16'h0000; ticks(3);

        // One key coin: exactly one pulse.
        coin_rises = 0;
        key(1, 0, 8'h2E); tick();
        key(0, 0, 8'h2E); ticks(150);
        check("key_coin_pulses", coin_rises, 1);

        // Three requests during a pulse: one queued coin only.
        coin_rises = 0;
        joy_coin();
        wait_coin("coin_start_a");
        joy_coin(); joy_coin(); joy_coin();
        ticks(250);
        check("queued_coin_pulses", coin_rises, 2);

        // Reset mid-pulse with a coin pending.
        joy_coin();
        wait_coin("coin_start_b");
        joy_coin();
        async_reset(2);
        coin_rises = 0;
        ticks(200);
        check("post_reset_pulses", coin_rises, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 4) == 0) key(1'($urandom), 1'($urandom), 8'($urandom));
                else key(1'($urandom), 1'($urandom), codes[$urandom_range(0, 16)]);
            end
            if ($urandom_range(0, 7) == 0) joy0 = rand_joy();
            if ($urandom_range(0, 7) == 0) joy1 = rand_joy();
            if (vb_ph == 0 && $urandom_range(0, 3) == 0) vb_period = $urandom_range(4, 20);
            tick();
        end

        @(negedge clk_sys);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
